// File: rtl/freq_synth_if.sv
// Control/status bundle for freq_synth: frequency request, enable and waveform status.
// pulse_count is carried only when FREQSYNTH_PULSECOUNT_EN is defined.
interface freq_synth_if;
    logic [31:0] freq_word;
    logic        load;
    logic        enable;
    logic        signalOut;
    logic        ready;
    logic [31:0] half_period;
    logic        sat;
`ifdef FREQSYNTH_PULSECOUNT_EN
    logic [31:0] pulse_count;

    modport master (output freq_word, load, enable,
                    input  signalOut, ready, half_period, sat, pulse_count);
    modport slave  (input  freq_word, load, enable,
                    output signalOut, ready, half_period, sat, pulse_count);
`else
    modport master (output freq_word, load, enable,
                    input  signalOut, ready, half_period, sat);
    modport slave  (input  freq_word, load, enable,
                    output signalOut, ready, half_period, sat);
`endif
endinterface

// File: rtl/freq_synth.sv
// Programmable square-wave generator; half-period = CLK_HZ / (2*freq_word) from a restoring divider.
// Optional rising-edge pulse counter enabled by defining FREQSYNTH_PULSECOUNT_EN.
module freq_synth #(
    parameter int unsigned CLK_HZ = 50000000
) (
    input  logic        clock,
    input  logic        reset_n,
    freq_synth_if.slave bus
);
    localparam int unsigned W  = 32;
    localparam int unsigned DW = W + 1;
    localparam int unsigned RW = W + 2;
    localparam int unsigned CW = 5;
    localparam logic [W-1:0] DIVIDEND = W'(CLK_HZ);

    typedef enum logic [1:0] {IDLE, DIVIDE, RUN} state_t;

    state_t        state, state_n;
    logic [DW-1:0] divisor, divisor_n;
    logic [DW-1:0] rem, rem_n;
    logic [W-1:0]  quo, quo_n;
    logic [CW-1:0] iter, iter_n;
    logic          wave_on, wave_on_n;
    logic [W-1:0]  phase, phase_n;
    logic          out_q, out_n;
    logic          ready_q, ready_n;
    logic [W-1:0]  hp_q, hp_n;
    logic          sat_q, sat_n;

    logic [RW-1:0] trial;
    logic          ge;
    logic [W-1:0]  quo_step;
    logic          stop;
    logic          active;

    // State register
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_n;
    end

    // Next-state, divider iteration and toggle stage
    always_comb begin
        state_n   = state;
        divisor_n = divisor;
        rem_n     = rem;
        quo_n     = quo;
        iter_n    = iter;
        wave_on_n = wave_on;
        phase_n   = phase;
        out_n     = out_q;
        ready_n   = ready_q;
        hp_n      = hp_q;
        sat_n     = sat_q;

        // quo holds the remaining dividend bits in its MSBs and collects quotient bits at the LSB
        trial    = {rem, quo[W-1]};
        ge       = (trial >= RW'(divisor));
        quo_step = {quo[W-2:0], ge};
        stop     = bus.load && (bus.freq_word == '0);
        active   = bus.enable && wave_on && !stop;

        case (state)
            DIVIDE: begin
                rem_n  = ge ? DW'(trial - RW'(divisor)) : DW'(trial);
                quo_n  = quo_step;
                iter_n = iter + CW'(1);
                if (iter == CW'(W - 1)) begin
                    state_n   = RUN;
                    ready_n   = 1'b1;
                    wave_on_n = 1'b1;
                    if (quo_step == '0) begin
                        hp_n  = W'(1);
                        sat_n = 1'b1;
                    end else begin
                        hp_n  = quo_step;
                        sat_n = 1'b0;
                    end
                end
            end
            IDLE, RUN: begin
            end
            default: state_n = IDLE;
        endcase

        // A load always wins over a divide in flight
        if (bus.load) begin
            if (stop) begin
                state_n   = IDLE;
                ready_n   = 1'b1;
                hp_n      = '0;
                sat_n     = 1'b0;
                wave_on_n = 1'b0;
            end else begin
                state_n   = DIVIDE;
                ready_n   = 1'b0;
                divisor_n = {bus.freq_word, 1'b0};
                rem_n     = '0;
                quo_n     = DIVIDEND;
                iter_n    = '0;
            end
        end

        // ">=" lets a shortened half-period take effect without producing a runt
        if (active) begin
            if (phase >= hp_q - W'(1)) begin
                out_n   = ~out_q;
                phase_n = '0;
            end else begin
                phase_n = phase + W'(1);
            end
        end else begin
            out_n   = 1'b0;
            phase_n = '0;
        end
    end

    // Datapath registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            divisor <= '0;
            rem     <= '0;
            quo     <= '0;
            iter    <= '0;
            wave_on <= 1'b0;
            phase   <= '0;
            out_q   <= 1'b0;
            ready_q <= 1'b1;
            hp_q    <= '0;
            sat_q   <= 1'b0;
        end else begin
            divisor <= divisor_n;
            rem     <= rem_n;
            quo     <= quo_n;
            iter    <= iter_n;
            wave_on <= wave_on_n;
            phase   <= phase_n;
            out_q   <= out_n;
            ready_q <= ready_n;
            hp_q    <= hp_n;
            sat_q   <= sat_n;
        end
    end

    assign bus.signalOut   = out_q;
    assign bus.ready       = ready_q;
    assign bus.half_period = hp_q;
    assign bus.sat         = sat_q;

`ifdef FREQSYNTH_PULSECOUNT_EN
    logic [W-1:0] pcount;

    // Rising edges of signalOut, cleared by any load
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n)              pcount <= '0;
        else if (bus.load)         pcount <= '0;
        else if (out_n && !out_q)  pcount <= pcount + W'(1);
    end

    assign bus.pulse_count = pcount;
`endif

endmodule

// File: doc/freq_synth.md
# freq_synth

Programmable square-wave generator that drives `signalOut` at a requested frequency in Hz. It is the stimulus source for the frequency counter: the same Hz-valued word the counter displays is what this block accepts. The half-period is computed on-chip by a sequential restoring divider, so no pre-computed divisor is needed. The output runs through a glitch-free counter/toggle stage.

## Interface
- `CLK_HZ`, 50000000, clock frequency in Hz. Constant dividend; must be < 2^32.
- `clock`  input  1  system clock; all flops on rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `freq_word`  input  32  requested output frequency, Hz.
- `load`  input  1  one-cycle strobe; captures `freq_word`.
- `enable`  input  1  level; 0 forces output low and restarts phase.
- `signalOut`  output  1  generated square wave, 50% duty.
- `ready`  output  1  1 when no division is in progress.
- `half_period`  output  32  active half-period in clock cycles.
- `sat`  output  1  request exceeded CLK_HZ/2 and was clamped.
- `pulse_count`  output  32  rising edges of `signalOut`; present only with `FREQSYNTH_PULSECOUNT_EN`.

## Operation
- States: IDLE (no waveform), DIVIDE, RUN.
- Reset: state IDLE, `signalOut`=0, `ready`=1, `half_period`=0, `sat`=0, phase counter 0, `pulse_count`=0.
- `load` with `freq_word`=0: state goes to IDLE on the next edge, and `signalOut` goes 0 on the same edge. `half_period`=0, `sat`=0, `ready` stays 1, no divide.
- `load` with nonzero word: the word is latched and state goes to DIVIDE with `ready`=0.
  - Divisor = 2*freq_word, 33 bits. Quotient = floor(CLK_HZ/divisor), computed 1 bit per cycle over 32 cycles.
  - Quotient 0 (word > CLK_HZ/2): `half_period`=1 and `sat`=1. Otherwise `half_period`=quotient and `sat`=0.
  - On completion, state goes to RUN and `ready`=1.
- `load` during DIVIDE aborts the current divide and restarts it with the new word. The old `half_period` is kept until completion.
- During DIVIDE the previous waveform continues unchanged. If the previous state was IDLE, the output stays low.
- RUN with `enable`=1: the phase counter increments each cycle. When counter ≥ `half_period`-1, `signalOut` toggles and the counter clears. Period = 2*`half_period` cycles.
- When a new `half_period` is installed while running, the comparison uses the new value from the next edge. If the counter already meets the new threshold, toggle on that edge. No runt pulse shorter than min(old,new) half-period is produced.
- `enable`=0 in any state: `signalOut`=0 and counter held at 0. Divides still proceed.
- `enable` 0→1 in RUN: the first rising edge of `signalOut` occurs `half_period` cycles later.
- Arithmetic is unsigned. Quotient truncates. No rounding.

## Timing
- `load` sampled at edge E0: `ready`=0 after E0. Divide iterations occur on E1..E32.
- At E32, `half_period` and `sat` are updated, `ready`=1, and state becomes RUN.
- Load→`ready` latency: 32 cycles after the sampled edge.
- From IDLE, the first `signalOut` rise occurs at E32+`half_period`.
- Toggle occurs on the edge where counter = `half_period`-1, giving `signalOut` high for exactly `half_period` cycles.
- `reset_n` asserted mid-operation: all outputs return to their reset values immediately. A divide in progress is discarded.
- `load` and `enable` falling on the same edge: both take effect. The output goes low and the divide starts.

## Configuration
- `FREQSYNTH_PULSECOUNT_EN` defined:
  - `pulse_count` port exists and increments on each cycle where `signalOut` goes 0→1.
  - Wraps at 2^32.
  - Clears on reset and on any `load`.
- Not defined: the port and counter are absent. All other behaviour is identical.

## Test plan
- CLK_HZ=1000, load 100, enable=1:
  - `ready` low 32 cycles, then `half_period`=5 and `sat`=0.
  - `signalOut` period 10 cycles, high 5.
  - First rise 5 cycles after `ready`.
- CLK_HZ=1000, load 3: `half_period`=166 (truncated), period 332 cycles.
- CLK_HZ=1000, load 600: `half_period`=1, `sat`=1, output toggles every cycle.
- Running at 100, load 50 (expected `half_period`=10):
  - Old 10-cycle period continues during the divide.
  - After `ready`, the period becomes 20 with no half-period under 5 cycles.
  - Re-load of 25 at divide cycle 10: `ready` returns 32 cycles after the re-load, with `half_period`=20.
- Running, then load 0: `signalOut`=0 next edge, `half_period`=0, `ready` stays 1. Toggle `enable`: no activity.
- Mid-divide `reset_n` low: all outputs at reset values, `ready`=1.
  - With `FREQSYNTH_PULSECOUNT_EN`, at 100 Hz for 100 cycles after `ready`: `pulse_count`=10.
